// File: rtl/md_pkg.sv
// md_pkg: shared types and helpers for the md_unit multiply/divide unit.
// Holds operation and state encodings, the request payload and operation predicates.
package md_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] SIGN_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Request payload as seen on the bus when start is sampled.
  typedef struct packed {
    md_op_e           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } md_req_t;

  function automatic logic is_div(input md_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_a(input md_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input md_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Result for divide-by-zero (dz=1) or signed overflow (dz=0).
  function automatic logic [WIDTH-1:0] special_result(input md_op_e op,
                                                      input logic [WIDTH-1:0] a,
                                                      input logic dz);
    logic [WIDTH-1:0] r;
    if (dz) r = is_rem(op) ? a : ALL_ONES;
    else    r = is_rem(op) ? '0 : SIGN_MIN;
    return r;
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: start/busy/done handshake plus operand and result bus of md_unit.
interface md_unit_if;
  import md_pkg::*;

  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;

  // Control unit side.
  modport master (
    output start, md_op, a, b,
    input  busy, done, res
  );

  // Multiply/divide unit side.
  modport slave (
    input  start, md_op, a, b,
    output busy, done, res
  );
endinterface

// File: rtl/md_divstep.sv
// md_divstep: one restoring-division iteration (shift in dividend bit, trial subtract).
module md_divstep
  import md_pkg::*;
(
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_trial = w_shift - {1'b0, i_divisor};
    o_q     = ~w_trial[WIDTH];
    o_rem   = o_q ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative RV32M multiply/divide unit (shift-add multiplier, restoring divider).
// Optional build macro MD_EARLY_OUT_EN: divide-by-zero and signed overflow skip
// CALC/FIX and finish one cycle after start; otherwise they take the full latency.
module md_unit
  import md_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  md_unit_if.slave  md_bus
);

  md_state_e          r_state;
  md_op_e             r_op;
  logic [WIDTH-1:0]   r_a_raw;
  logic [WIDTH-1:0]   r_opnd;      // multiplicand magnitude, or divisor magnitude
  logic [2*WIDTH-1:0] r_acc;       // product, or dividend shifting into quotient
  logic [WIDTH-1:0]   r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic               r_ovf;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_res;
  logic               r_busy;
  logic               r_done;

  md_req_t            w_req;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_dz;
  logic               w_ovf;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_acc;

  logic [WIDTH-1:0]   w_div_rem;
  logic               w_div_q;
  logic [2*WIDTH-1:0] w_div_acc;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rmd;
  logic [WIDTH-1:0]   w_fix;

  assign md_bus.busy = r_busy;
  assign md_bus.done = r_done;
  assign md_bus.res  = r_res;

  // Decode incoming request: operand magnitudes, signs and special cases.
  always_comb begin
    w_req.op = md_op_e'(md_bus.md_op);
    w_req.a  = md_bus.a;
    w_req.b  = md_bus.b;
    w_neg_a  = is_signed_a(w_req.op) & w_req.a[WIDTH-1];
    w_neg_b  = is_signed_b(w_req.op) & w_req.b[WIDTH-1];
    w_a_mag  = w_neg_a ? WIDTH'(-w_req.a) : w_req.a;
    w_b_mag  = w_neg_b ? WIDTH'(-w_req.b) : w_req.b;
    w_dz     = is_div(w_req.op) & (w_req.b == '0);
    w_ovf    = is_div(w_req.op) & is_signed_a(w_req.op)
             & (w_req.a == SIGN_MIN) & (w_req.b == ALL_ONES);
  end

  // Shift-add step: conditionally add multiplicand to high half, shift right.
  always_comb begin
    w_addend  = r_acc[0] ? r_opnd : '0;
    w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};
  end

  md_divstep u_divstep (
    .i_rem     (r_rem),
    .i_bit     (r_acc[WIDTH-1]),
    .i_divisor (r_opnd),
    .o_rem     (w_div_rem),
    .o_q       (w_div_q)
  );

  // Dividend bits leave at the top of the low half while quotient bits enter at the bottom.
  assign w_div_acc = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_div_q};

  // Sign correction and result selection, with special cases overriding.
  always_comb begin
    w_prod = r_neg_q ? (2*WIDTH)'(-r_acc) : r_acc;
    w_quo  = r_neg_q ? WIDTH'(-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    w_rmd  = r_neg_r ? WIDTH'(-r_rem) : r_rem;
    if (r_dz || r_ovf) begin
      w_fix = special_result(r_op, r_a_raw, r_dz);
    end else if (is_div(r_op)) begin
      w_fix = is_rem(r_op) ? w_rmd : w_quo;
    end else if (r_op == OP_MUL) begin
      w_fix = w_prod[WIDTH-1:0];
    end else begin
      w_fix = w_prod[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_MUL;
      r_a_raw  <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      r_res    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (md_bus.start) begin
            r_op    <= w_req.op;
            r_a_raw <= w_req.a;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dz    <= w_dz;
            r_ovf   <= w_ovf;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            if (is_div(w_req.op)) begin
              r_opnd <= w_b_mag;
              r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
            end else begin
              r_opnd <= w_a_mag;
              r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
            end
`ifdef MD_EARLY_OUT_EN
            if (w_dz || w_ovf) begin
              r_result <= special_result(w_req.op, w_req.a, w_dz);
              r_state  <= ST_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= ST_CALC;
            end
`else
            r_busy  <= 1'b1;
            r_state <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          if (is_div(r_op)) begin
            r_acc <= w_div_acc;
            r_rem <= w_div_rem;
          end else begin
            r_acc <= w_mul_acc;
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH-1)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_result <= w_fix;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_res   <= r_result;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized self-checking bench for md_unit against an arithmetic reference.
module tb_md_unit;
  import md_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [W-1:0] prev_res;

  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit u_dut (
    .clk    (clk),
    .rstn   (rstn),
    .md_bus (bus.slave)
  );

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // RV32M reference result from plain integer arithmetic.
  function automatic logic [W-1:0] ref_md(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint      sa, sb, ub;
    logic [63:0] pu, ps;
    logic [W-1:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    pu = {32'd0, a} * {32'd0, b};
    r  = '0;
    case (op)
      3'd0: r = pu[31:0];
      3'd1: begin ps = sa * sb; r = ps[63:32]; end
      3'd2: begin ps = sa * ub; r = ps[63:32]; end
      3'd3: r = pu[63:32];
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin ps = sa / sb; r = ps[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin ps = sa % sb; r = ps[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    return op[2] && ((b == 0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Issue one operation and check handshake timing, result and hold behaviour.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inject_at);
    logic [W-1:0] exp;
    int           lat;
    int           bad;
    bit           early;
    string        tag;
    exp   = ref_md(op, a, b);
    early = 1'b0;
`ifdef MD_EARLY_OUT_EN
    early = is_special(op, a, b);
`endif
    lat = early ? 1 : W + 2;
    tag = $sformatf("op%0d a=%08h b=%08h", op, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.md_op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
    bad = 0;
    for (int k = 0; k <= lat + 1; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k < lat) begin
        if (bus.busy !== (early ? 1'b0 : 1'b1)) bad++;
        if (bus.done !== 1'b0) bad++;
        if (bus.res !== prev_res) bad++;
        if (k == inject_at) begin
          bus.start = 1'b1; bus.md_op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
        end else begin
          bus.start = 1'b0;
        end
      end else if (k == lat) begin
        bus.start = 1'b0;
        check({"done ", tag}, 32'(bus.done), 32'd1);
        check({"busy_at_done ", tag}, 32'(bus.busy), 32'd0);
        check({"res ", tag}, bus.res, exp);
      end else begin
        check({"done_pulse ", tag}, 32'(bus.done), 32'd0);
        check({"res_hold ", tag}, bus.res, exp);
      end
    end
    check({"profile ", tag}, 32'(bad), 32'd0);
    prev_res = exp;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b;
    rstn      = 1'b0;
    bus.start = 1'b0; bus.md_op = 3'd0; bus.a = '0; bus.b = '0;
    prev_res  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_res", bus.res, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Directed cases from the operation rules.
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, -1);
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, -1);
    run_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, -1);
    run_op(3'd2, 32'hFFFF_FFFF,  32'd2,         -1);
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         -1);
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         -1);
    run_op(3'd5, 32'd100,        32'd7,         -1);
    run_op(3'd7, 32'd100,        32'd7,         -1);
    run_op(3'd5, 32'h1234_5678,  32'd0,         -1);
    run_op(3'd7, 32'h1234_5678,  32'd0,         -1);
    run_op(3'd4, 32'h8765_4321,  32'd0,         -1);
    run_op(3'd6, 32'h8765_4321,  32'd0,         -1);
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, -1);
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, -1);

    // Start pulse with new operands while busy is ignored.
    run_op(3'd4, 32'd1000, 32'hFFFF_FFFD, 5);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd0; bus.a = 32'h0001_2345; bus.b = 32'd99;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_done", 32'(bus.done), 32'd0);
    check("midreset_res", bus.res, 32'd0);
    prev_res = '0;
    @(negedge clk);
    rstn = 1'b1;
    run_op(3'd0, 32'h0001_2345, 32'd99, -1);

    // Randomized operations with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      run_op(op, a, b, (i % 3 == 0) ? int'($urandom_range(0, 20)) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
